serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder.sv | 127 ++++++++++++
 tb/tb_serial_adder.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial ripple adder: one full-adder bit per clock, LSB first, WIDTH cycles per sum.
// Optional signed-overflow output is enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_ADD, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             bit_s, bit_c;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  // Returns {carry_out, sum_bit}.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic c);
    return {(x & y) | (c & (x ^ y)), x ^ y ^ c};
  endfunction

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif
    {bit_c, bit_s} = full_add(a_sh_q[0], b_sh_q[0], carry_q);

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = cin;
          res_d   = '0;
          cnt_d   = '0;
          state_d = S_ADD;
        end
      end
      S_ADD: begin
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        carry_d = bit_c;
        res_d   = {bit_s, res_q[WIDTH-1:1]};
        cnt_d   = cnt_q + CNT_W'(1);
        // Final bit: publish the result including the bit being formed this cycle.
        if (cnt_q == LAST_BIT) begin
          state_d = S_DONE;
          sum_d   = res_d;
          cout_d  = bit_c;
`ifdef SERIAL_ADDER_OVF_EN
          ovf_d   = carry_q ^ bit_c;
`endif
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy = (state_q == S_ADD);
  assign done = (state_q == S_DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: directed WIDTH=8 vectors plus exhaustive WIDTH=2 sweep.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst;
  logic       start8, cin8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;
  logic       start2, cin2, busy2, done2, cout2;
  logic [1:0] a2, b2, sum2;
`ifdef SERIAL_ADDER_OVF_EN
  logic       ovf8, ovf2;
`endif

  int n_vec = 0;
  int n_err = 0;
  int ops8 = 0, dones8 = 0;
  int ops2 = 0, dones2 = 0;

  typedef struct packed {logic [7:0] s; logic c; logic o;} exp8_t;
  typedef struct packed {logic [1:0] s; logic c; logic o;} exp2_t;
  exp8_t q8[$];
  exp2_t q2[$];

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf8)
`endif
  );

  serial_adder #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .cin(cin2),
    .busy(busy2), .done(done2), .sum(sum2), .cout(cout2)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf2)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitors: pop one expected result per done pulse.
  initial forever begin
    exp8_t e;
    @(negedge clk);
    if (done8 === 1'b1) begin
      dones8++;
      if (q8.size() == 0) check("unexpected_done8", {31'b0, done8}, 32'd0);
      else begin
        e = q8.pop_front();
        check("sum8", {24'b0, sum8}, {24'b0, e.s});
        check("cout8", {31'b0, cout8}, {31'b0, e.c});
`ifdef SERIAL_ADDER_OVF_EN
        check("ovf8", {31'b0, ovf8}, {31'b0, e.o});
`endif
      end
    end
  end

  initial forever begin
    exp2_t e;
    @(negedge clk);
    if (done2 === 1'b1) begin
      dones2++;
      if (q2.size() == 0) check("unexpected_done2", {31'b0, done2}, 32'd0);
      else begin
        e = q2.pop_front();
        check("sum2", {30'b0, sum2}, {30'b0, e.s});
        check("cout2", {31'b0, cout2}, {31'b0, e.c});
`ifdef SERIAL_ADDER_OVF_EN
        check("ovf2", {31'b0, ovf2}, {31'b0, e.o});
`endif
      end
    end
  end

  // Called at a negedge; returns at a negedge with the DUT back in IDLE.
  task automatic run_op8(input logic [7:0] ta, input logic [7:0] tb, input logic tci,
                         input logic [7:0] es, input logic ec, input logic eo, input bit hold);
    int edges = 0;
    int busy_n = 0;
    bit seen = 0;
    q8.push_back('{s: es, c: ec, o: eo});
    ops8++;
    a8 = ta; b8 = tb; cin8 = tci; start8 = 1'b1;
    while (!seen && edges < 20) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (busy8) busy_n++;
      if (done8) seen = 1;
      else if (hold) begin
        start8 = 1'b1; a8 = a8 + 8'h13; b8 = b8 ^ 8'hA5; cin8 = ~cin8;
      end else start8 = 1'b0;
    end
    check("done_seen", {31'b0, seen}, 32'd1);
    check("latency_edges", edges, 32'd9);
    check("busy_cycles", busy_n, 32'd8);
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    check("done_one_cycle", {31'b0, done8}, 32'd0);
    repeat (2) @(negedge clk);
    check("sum_hold", {24'b0, sum8}, {24'b0, es});
    check("idle_busy", {31'b0, busy8}, 32'd0);
  endtask

  task automatic run_op2(input logic [1:0] ta, input logic [1:0] tb, input logic tci);
    int edges = 0;
    bit seen = 0;
    logic [2:0] tot;
    tot = {1'b0, ta} + {1'b0, tb} + {2'b0, tci};
    q2.push_back('{s: tot[1:0], c: tot[2], o: (ta[1] == tb[1]) && (tot[1] != ta[1])});
    ops2++;
    a2 = ta; b2 = tb; cin2 = tci; start2 = 1'b1;
    while (!seen && edges < 10) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      start2 = 1'b0;
      if (done2) seen = 1;
    end
    check("w2_latency", edges, 32'd3);
    @(negedge clk);
  endtask

  initial begin
    bit saw_done;
    rst = 1'b1;
    start8 = 0; a8 = 0; b8 = 0; cin8 = 0;
    start2 = 0; a2 = 0; b2 = 0; cin2 = 0;
    repeat (2) @(negedge clk);
    check("rst_busy8", {31'b0, busy8}, 32'd0);
    check("rst_done8", {31'b0, done8}, 32'd0);
    check("rst_sum8", {24'b0, sum8}, 32'd0);
    check("rst_cout8", {31'b0, cout8}, 32'd0);
    check("rst_busy2", {31'b0, busy2}, 32'd0);
    check("rst_sum2", {30'b0, sum2}, 32'd0);

    // Start accepted on the very first edge after reset release.
    rst = 1'b0;
    run_op8(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1, 0);
    run_op8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 0);
    run_op8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 0);
    run_op8(8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0, 1);

    // Abort in the 4th ADD cycle.
    a8 = 8'h11; b8 = 8'h22; cin8 = 1'b0; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_abort_busy", {31'b0, busy8}, 32'd1);
    rst = 1'b1;
    #1;
    check("abort_busy", {31'b0, busy8}, 32'd0);
    check("abort_done", {31'b0, done8}, 32'd0);
    check("abort_sum", {24'b0, sum8}, 32'd0);
    check("abort_cout", {31'b0, cout8}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    saw_done = 0;
    repeat (12) begin
      @(negedge clk);
      if (done8) saw_done = 1;
    end
    check("no_done_after_abort", {31'b0, saw_done}, 32'd0);
    check("sum_after_abort", {24'b0, sum8}, 32'd0);
    run_op8(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0, 0);

    run_op8(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 0);
    run_op8(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 0);

    for (int i = 0; i < 32; i++) begin
      logic [4:0] v;
      v = 5'(i);
      run_op2(v[1:0], v[3:2], v[4]);
    end

    repeat (3) @(negedge clk);
    check("dones8_vs_ops8", dones8, ops8);
    check("dones2_vs_ops2", dones2, ops2);
    check("q8_drained", q8.size(), 32'd0);
    check("q2_drained", q2.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
